// File: rtl/i2c_master.sv
// Single-byte I2C register-access master: write and random-read transactions, open-drain SCL/SDA.
// Optional SCL clock stretching is enabled by defining I2C_MASTER_STRETCH_EN.
module i2c_master #(
    parameter int CLK_DIV   = 25,
    parameter int DIV_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_DEVW, ST_ACK1, ST_REG, ST_ACK2, ST_WDATA, ST_ACK3,
        ST_RSTART, ST_DEVR, ST_ACK4, ST_RDATA, ST_MNACK, ST_STOP, ST_DONE
    } state_e;

    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           qtr_q, qtr_d;
    logic [2:0]           bit_q, bit_d;
    logic [6:0]           dev_q, dev_d;
    logic [7:0]           reg_q, reg_d, wdata_q, wdata_d;
    logic [7:0]           rx_q, rx_d, rdata_q, rdata_d;
    logic                 rd_q, rd_d, nack_q, nack_d, ack_err_q, ack_err_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 scl_q, scl_d, sda_q, sda_d;
    logic                 hold_s, qend_s, sample_s, bit_end_s, is_ack_s, is_byte_s;
    logic [7:0]           tx_byte_s;

`ifdef I2C_MASTER_STRETCH_EN
    // A released SCL held low by the slave freezes the quarter counter at 0 in q2
    always_comb begin
        if ((qtr_q == 2'd2) && scl_q && (cnt_q == CNT_ZERO) && !scl_i) begin
            hold_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
    end
`else
    logic unused_scl_s;
    assign unused_scl_s = scl_i;
    assign hold_s       = 1'b0;
`endif

    assign qend_s    = (cnt_q == CNT_LAST) && !hold_s;
    assign sample_s  = qend_s && (qtr_q == 2'd2);
    assign bit_end_s = qend_s && (qtr_q == 2'd3);
    assign is_ack_s  = (state_q == ST_ACK1) || (state_q == ST_ACK2) ||
                       (state_q == ST_ACK3) || (state_q == ST_ACK4);
    assign is_byte_s = (state_q == ST_DEVW) || (state_q == ST_REG) || (state_q == ST_WDATA) ||
                       (state_q == ST_DEVR) || (state_q == ST_RDATA);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            rdata_q   <= 8'h00;
            rd_q      <= 1'b0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    // Next-state, bit timing and sampled data
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                qtr_d = 2'd0;
                bit_d = 3'd0;
                if (cmd_valid) begin
                    dev_d     = cmd_dev;
                    reg_d     = cmd_reg;
                    wdata_d   = cmd_wdata;
                    rd_d      = cmd_rd;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (hold_s) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    qtr_d = qtr_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (sample_s && is_ack_s) begin
                    nack_d    = sda_i;
                    ack_err_d = ack_err_q | sda_i;
                end else if (sample_s && (state_q == ST_RDATA)) begin
                    rx_d = {rx_q[6:0], sda_i};
                end else begin
                    nack_d = nack_q;
                end
                if (bit_end_s) begin
                    bit_d = (is_byte_s && (bit_q != 3'd7)) ? bit_q + 3'd1 : 3'd0;
                    case (state_q)
                        ST_START:  state_d = ST_DEVW;
                        ST_DEVW:   state_d = (bit_q == 3'd7) ? ST_ACK1 : ST_DEVW;
                        ST_ACK1:   state_d = nack_q ? ST_STOP : ST_REG;
                        ST_REG:    state_d = (bit_q == 3'd7) ? ST_ACK2 : ST_REG;
                        ST_ACK2:   state_d = nack_q ? ST_STOP : (rd_q ? ST_RSTART : ST_WDATA);
                        ST_WDATA:  state_d = (bit_q == 3'd7) ? ST_ACK3 : ST_WDATA;
                        ST_ACK3:   state_d = ST_STOP;
                        ST_RSTART: state_d = ST_DEVR;
                        ST_DEVR:   state_d = (bit_q == 3'd7) ? ST_ACK4 : ST_DEVR;
                        ST_ACK4:   state_d = nack_q ? ST_STOP : ST_RDATA;
                        ST_RDATA: begin
                            if (bit_q == 3'd7) begin
                                rdata_d = rx_q;
                                state_d = ST_MNACK;
                            end else begin
                                state_d = ST_RDATA;
                            end
                        end
                        ST_MNACK:  state_d = ST_STOP;
                        ST_STOP:   state_d = ST_DONE;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // Line levels and handshake flags, computed from the upcoming state so they register in phase
    always_comb begin
        case (state_d)
            ST_DEVW:  tx_byte_s = {dev_q, 1'b0};
            ST_REG:   tx_byte_s = reg_q;
            ST_WDATA: tx_byte_s = wdata_q;
            ST_DEVR:  tx_byte_s = {dev_q, 1'b1};
            default:  tx_byte_s = 8'hFF;
        endcase
        case (state_d)
            ST_START: begin
                scl_d = (qtr_d != 2'd3);
                sda_d = (qtr_d == 2'd0);
            end
            ST_DEVW, ST_REG, ST_WDATA, ST_DEVR: begin
                scl_d = qtr_d[1];
                sda_d = tx_byte_s[3'd7 - bit_d];
            end
            ST_ACK1, ST_ACK2, ST_ACK3, ST_ACK4, ST_RDATA, ST_MNACK: begin
                scl_d = qtr_d[1];
                sda_d = 1'b1;
            end
            ST_RSTART: begin
                scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_d = !qtr_d[1];
            end
            ST_STOP: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = qtr_d[1];
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign scl_o   = scl_q;
    assign sda_o   = sda_q;
endmodule
